// File: rtl/prog_counter_timer.sv
// Loadable up/down counter/timer with modulo limit, prescaler and
// wrap / saturate / one-shot terminal behaviours.
// Ports: clk, rst_n (async, active-low); en, load, load_val, dir, mode,
//   limit, prescale, start in; count, tc, sat, running, done out.
module prog_counter_timer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  start,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  sat,
  output logic                  running,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [PRESCALE_W-1:0] pre_q;
  logic [PRESCALE_W-1:0] pre_d;
  logic [WIDTH-1:0]      count_d;
  logic                  tc_d;
  logic                  sat_d;
  logic                  done_d;

  logic one_shot;
  logic active;
  logic arm;
  logic adv;
  logic tick;
  logic term;

  assign one_shot = (mode == 2'b10);
  assign active   = en && (!one_shot || state_q == RUN);
  assign running  = active;

  // arm can only fire outside RUN, so it never overlaps adv
  assign arm  = !load && en && one_shot && (state_q != RUN) && start;
  assign adv  = active && !load;
  assign tick = (pre_q == prescale);

  // terminal check is taken before the step, so an up-count never
  // passes limit unless limit is the all-ones value
  assign term = dir ? (count >= limit) : (count == '0);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    count_d = count;
    tc_d    = 1'b0;
    sat_d   = sat;
    done_d  = done;

    unique case (1'b1)
      load: begin
        count_d = load_val;
        pre_d   = '0;
        sat_d   = 1'b0;
        done_d  = 1'b0;
      end
      arm: begin
        count_d = load_val;
        pre_d   = '0;
        done_d  = 1'b0;
        state_d = RUN;
      end
      adv: begin
        if (!tick) begin
          pre_d = pre_q + PRESCALE_W'(1);
        end else begin
          pre_d = '0;
          tc_d  = term;
          sat_d = term && (mode == 2'b01);
          if (!term) begin
            count_d = dir ? count + WIDTH'(1)
                          : count - WIDTH'(1);
          end else begin
            unique case (mode)
              2'b01: ;
              2'b10: begin
                state_d = DONE;
                done_d  = 1'b1;
              end
              default: count_d = dir ? '0 : limit;
            endcase
          end
        end
      end
      default: ;
    endcase

    // leaving one-shot mode drops the FSM back to idle
    if (!one_shot) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      count   <= '0;
      tc      <= 1'b0;
      sat     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      count   <= count_d;
      tc      <= tc_d;
      sat     <= sat_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_prog_counter_timer.sv
// Randomised and directed bench for prog_counter_timer, checking an
// 8-bit and a 16-bit instance against a behavioural model.
module tb_prog_counter_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] load_val16;
  logic        dir;
  logic [1:0]  mode;
  logic [15:0] limit16;
  logic [3:0]  prescale;
  logic        start;

  logic [7:0]  cnt8;
  logic        tc8, sat8, run8, done8;
  logic [15:0] cnt16;
  logic        tc16, sat16, run16, done16;

  int errors = 0;
  int checks = 0;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  int m_cnt [2];
  int m_pre [2];
  int m_st  [2];
  bit m_tc  [2];
  bit m_sat [2];
  bit m_done[2];

  always #5 clk = ~clk;

  prog_counter_timer #(.WIDTH(8), .PRESCALE_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .load_val(load_val16[7:0]), .dir(dir), .mode(mode),
    .limit(limit16[7:0]), .prescale(prescale), .start(start),
    .count(cnt8), .tc(tc8), .sat(sat8), .running(run8),
    .done(done8)
  );

  prog_counter_timer #(.WIDTH(16), .PRESCALE_W(4)) u16 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .load_val(load_val16), .dir(dir), .mode(mode),
    .limit(limit16), .prescale(prescale), .start(start),
    .count(cnt16), .tc(tc16), .sat(sat16), .running(run16),
    .done(done16)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_pre[i]  = 0;
      m_st[i]   = S_IDLE;
      m_tc[i]   = 1'b0;
      m_sat[i]  = 1'b0;
      m_done[i] = 1'b0;
    end
  endfunction

  // One clock edge of the spec's rules, on plain integers.
  function automatic void model_step();
    for (int i = 0; i < 2; i++) begin
      int mask;
      int lv;
      int lim;
      bit act;
      bit tk;
      bit at_end;
      mask = (i == 0) ? 'hFF : 'hFFFF;
      lv   = int'(load_val16) & mask;
      lim  = int'(limit16) & mask;
      act  = en && (mode != 2 || m_st[i] == S_RUN);
      tk   = 1'b0;
      m_tc[i] = 1'b0;
      if (load) begin
        m_cnt[i]  = lv;
        m_pre[i]  = 0;
        m_sat[i]  = 1'b0;
        m_done[i] = 1'b0;
      end else if (en && mode == 2 && m_st[i] != S_RUN && start) begin
        m_cnt[i]  = lv;
        m_pre[i]  = 0;
        m_done[i] = 1'b0;
        m_st[i]   = S_RUN;
      end else if (act) begin
        if (m_pre[i] == int'(prescale)) begin
          m_pre[i] = 0;
          tk = 1'b1;
        end else begin
          m_pre[i] = (m_pre[i] + 1) % 16;
        end
      end
      if (tk) begin
        at_end = dir ? (m_cnt[i] >= lim) : (m_cnt[i] == 0);
        m_tc[i] = at_end;
        if (!at_end) begin
          m_cnt[i] = dir ? ((m_cnt[i] + 1) & mask)
                         : ((m_cnt[i] - 1) & mask);
          m_sat[i] = 1'b0;
        end else if (mode == 1) begin
          m_sat[i] = 1'b1;
        end else if (mode == 2) begin
          m_st[i]   = S_DONE;
          m_done[i] = 1'b1;
          m_sat[i]  = 1'b0;
        end else begin
          m_cnt[i] = dir ? 0 : lim;
          m_sat[i] = 1'b0;
        end
      end
      if (mode != 2) begin
        m_st[i]   = S_IDLE;
        m_done[i] = 1'b0;
      end
    end
  endfunction

  function automatic bit exp_run(input int i);
    return en && (mode != 2 || m_st[i] == S_RUN);
  endfunction

  task automatic compare_all();
    check("u8.count",   cnt8,   m_cnt[0]);
    check("u8.tc",      tc8,    m_tc[0]);
    check("u8.sat",     sat8,   m_sat[0]);
    check("u8.running", run8,   exp_run(0));
    check("u8.done",    done8,  m_done[0]);
    check("u16.count",  cnt16,  m_cnt[1]);
    check("u16.tc",     tc16,   m_tc[1]);
    check("u16.sat",    sat16,  m_sat[1]);
    check("u16.running",run16,  exp_run(1));
    check("u16.done",   done16, m_done[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val16 = '0;
    dir = 1'b0; mode = 2'b00; limit16 = '0; prescale = '0;
    start = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("rst.count", cnt8, 0);
    rst_n = 1'b1;

    // up wrap at limit 5
    en = 1'b1; dir = 1'b1; mode = 2'b00; limit16 = 16'd5;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t1.up", cnt8, k);
    end
    step();
    check("t1.wrap", cnt8, 0);
    check("t1.tc", tc8, 1);
    step();
    check("t1.after", cnt8, 1);
    check("t1.tc_one", tc8, 0);

    // load while disabled, then count down and reload from limit
    en = 1'b0; load = 1'b1; load_val16 = 16'h00A0;
    step();
    load = 1'b0;
    check("t2.load", cnt8, 8'hA0);
    en = 1'b1; dir = 1'b0; limit16 = 16'h0010;
    step();
    check("t2.dn", cnt8, 8'h9F);
    repeat (8'h9F) step();
    check("t2.zero", cnt8, 0);
    step();
    check("t2.reload", cnt8, 8'h10);
    check("t2.tc", tc8, 1);

    // saturate with prescale 2
    load = 1'b1; load_val16 = 16'h0000;
    step();
    load = 1'b0;
    mode = 2'b01; dir = 1'b1; limit16 = 16'd3; prescale = 4'd2;
    repeat (15) step();
    check("t3.hold", cnt8, 3);
    check("t3.sat", sat8, 1);
    dir = 1'b0;
    repeat (3) step();
    check("t3.off", cnt8, 2);
    check("t3.unsat", sat8, 0);

    // one-shot
    mode = 2'b10; load_val16 = 16'd2; prescale = 4'd0;
    step();
    start = 1'b1;
    step();
    check("t4.arm", cnt8, 2);
    check("t4.run", run8, 1);
    step();
    start = 1'b0;
    check("t4.ign", cnt8, 1);
    repeat (2) step();
    check("t4.done", done8, 1);
    check("t4.stop", run8, 0);
    check("t4.held", cnt8, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4.rerun", cnt8, 2);
    repeat (4) step();

    // asynchronous reset mid-count
    mode = 2'b00; dir = 1'b1; limit16 = 16'hFFFF;
    load = 1'b1; load_val16 = 16'h0030;
    step();
    load = 1'b0;
    repeat (7) step();
    check("t5.pre", cnt8, 8'h37);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t5.count", cnt8, 0);
    check("t5.tc", tc8, 0);
    check("t5.done", done8, 0);
    check("t5.c16", cnt16, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 16-bit natural overflow and load-over-tick
    load = 1'b1; load_val16 = 16'hFFFE;
    step();
    load = 1'b0;
    step();
    check("t6.max", cnt16, 16'hFFFF);
    step();
    check("t6.ovf", cnt16, 0);
    check("t6.tc", tc16, 1);
    load = 1'b1; load_val16 = 16'h1234;
    step();
    load = 1'b0;
    check("t6.ldwin", cnt16, 16'h1234);

    // randomised phase
    for (int n = 0; n < 3000; n++) begin
      en    = ($urandom_range(0, 9) != 0);
      load  = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 7) == 0);
      if (load) load_val16 = 16'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        dir      = 1'($urandom);
        mode     = 2'($urandom);
        prescale = 4'($urandom_range(0, 3));
        limit16  = ($urandom_range(0, 3) == 0) ? 16'hFFFF
                                                : 16'($urandom);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_counter_timer.md
Name: prog_counter_timer

Overview:
Parametrised, loadable counter/timer that generalises the team's 8-bit load/increment counter. It adds configurable width, up/down direction, a programmable modulo limit and a clock prescaler. It supports three terminal behaviours: wrap, saturate and one-shot. It sits behind the tile's dedicated I/O as a general timing and event-count resource.

Parameters:
- WIDTH, 8, counter width in bits.
- PRESCALE_W, 4, prescaler width; one tick occurs every (prescale+1) active cycles.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- en  in  1  global enable; when low, all state holds (load is still honoured)
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  value for load and one-shot start
- dir  in  1  1 = count up, 0 = count down
- mode  in  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved (behaves as 00)
- limit  in  WIDTH  terminal value for up-counting and reload value for down-wrap
- prescale  in  PRESCALE_W  tick divider
- start  in  1  one-shot arm pulse
- count  out  WIDTH  current count
- tc  out  1  terminal-count pulse, one cycle
- sat  out  1  high while saturated at the terminal value (mode 01)
- running  out  1  counter is advancing on ticks
- done  out  1  one-shot finished

Behaviour:
- Reset values: count=0, pre_cnt=0, tc=0, sat=0, done=0, FSM=IDLE. running=0 after reset, then follows its definition below.
- active = en && (mode!=10 || FSM==RUN). running = active.
- Prescaler, when active:
  - If pre_cnt==prescale: tick=1 and pre_cnt<=0.
  - Otherwise: pre_cnt<=pre_cnt+1.
  - prescale=0 gives a tick every active cycle.
  - When not active, pre_cnt holds.
- Terminal condition on tick:
  - up: count>=limit.
  - down: count==0.
- Priority: load > start > tick.
- load:
  - count<=load_val, pre_cnt<=0, sat<=0, done<=0.
  - Independent of en, and does not change FSM state.
  - No tick is processed in the load cycle.
- Tick, non-terminal: up gives count+1, down gives count-1. No tc.
- Tick, terminal, by mode:
  - wrap: up gives count<=0, down gives count<=limit.
  - saturate: count holds and sat<=1. sat clears on load, or on any tick that moves count off the terminal value (e.g. after dir changes).
  - one-shot: count holds, FSM RUN->DONE, done<=1.
- tc: registered; high exactly one cycle after each terminal tick. In saturate mode it pulses on every terminal tick.
- One-shot FSM, states IDLE, RUN, DONE:
  - IDLE/DONE + start: count<=load_val, pre_cnt<=0, done<=0, then RUN.
  - start while in RUN is ignored.
  - RUN + terminal tick: DONE.
  - Leaving mode 10 from any state: FSM returns to IDLE next cycle and done clears.
- Other mode/dir/limit/prescale changes take effect on the next tick with no flush. A limit lowered below count in up mode triggers the terminal condition on the next tick (>= compare).
- Arithmetic is modulo 2^WIDTH internally, but the terminal check precedes the increment/decrement. Natural 2^WIDTH overflow therefore occurs only if limit=2^WIDTH-1.
- Reset mid-operation: immediate return to reset values, asynchronously.

Test Plan:
- Reset, then en=1, dir=1, mode=00, limit=5, prescale=0 -> count 0,1,2,3,4,5,0,1; tc high exactly one cycle after the 5->0 tick.
- load=1, load_val=0xA0 with en=0 -> count=0xA0 next cycle. Then en=1, dir=0, limit=0x10 -> 0x9F, 0x9E, ...; on reaching 0, the next tick gives 0x10 with a tc pulse.
- mode=01, dir=1, limit=3, prescale=2 -> count advances every 3rd cycle to 3 then holds; sat=1; tc pulses every 3 cycles. Flip dir=0 -> next tick count=2, sat=0.
- mode=10, load_val=2, dir=0, prescale=0, start pulse -> running=1, count 2,1,0, then DONE: done=1, running=0, count holds 0. A start during RUN is ignored. A start in DONE reloads 2 and reruns.
- Assert rst_n low mid-count at count=0x37 -> count=0, tc=0, done=0 immediately without a clock edge.
- WIDTH=16, limit=0xFFFF, up wrap from load 0xFFFE -> 0xFFFF, then 0x0000 with tc. Also: a load and a tick in the same cycle -> load wins.
